pe2ddr_wr: RTL and testbench

- Write-back engine that drains per-PE accumulation buffers (abuf) to DDR over the ddr write interface.
- It is the transmit counterpart of the DDR-to-PE load path. For each PE enabled in conf_mask, in ascending index order, it issues one DDR write burst and reads conf_word_num words from that PE's buffer.
- Words are packed PACK per DDR beat and streamed with valid/ready handshakes.
- It sits between the PE array read ports and the ddr write channel and is started by the configuration unit.

---
 rtl/pe2ddr_wr_pkg.sv | 15 +
 rtl/pe2ddr_skid_fifo.sv | 49 ++++
 rtl/pe2ddr_wr.sv | 194 +++++++++++++++++++
 tb/tb_pe2ddr_wr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe2ddr_wr_pkg.sv
// Global system parameters shared by the PE-to-DDR write-back path.
package pe2ddr_wr_pkg;

    localparam int DDR_W      = 64;   // DDR beat width
    localparam int DDR_ADDR_W = 32;   // DDR byte address width
    localparam int BURST_W    = 9;    // burst length field width
    localparam int DATA_W     = 16;   // one PE datum
    localparam int BATCH      = 2;    // data per accumulation-buffer word

    // Bits needed to address x entries (at least one bit).
    function automatic int bw(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/pe2ddr_skid_fifo.sv
// Small first-word-fall-through FIFO that absorbs abuf read data while the
// DDR data channel is back-pressured.
module pe2ddr_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/pe2ddr_wr.sv
// Drains enabled PE accumulation buffers to DDR: one write burst per PE,
// words packed PACK per beat, LSB-first, short final beat zero-padded.
module pe2ddr_wr
    import pe2ddr_wr_pkg::*;
#(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = bw(BUF_DEPTH),
    parameter int RD_W       = BATCH * DATA_W,
    parameter int PACK       = DDR_W / RD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    output logic                    busy,
    input  logic [DDR_ADDR_W-1:0]   conf_st_addr,
    input  logic [DDR_ADDR_W-1:0]   conf_pe_step,
    input  logic [ADDR_W:0]         conf_word_num,
    input  logic [PE_NUM-1:0]       conf_mask,
    output logic [ADDR_W-1:0]       abuf_rd_addr,
    output logic [PE_NUM-1:0]       abuf_rd_en,
    input  logic [PE_NUM*RD_W-1:0]  abuf_rd_data,
    output logic [DDR_ADDR_W-1:0]   ddr_addr,
    output logic [BURST_W-1:0]      ddr_size,
    output logic                    ddr_addr_valid,
    input  logic                    ddr_addr_ready,
    output logic [DDR_W-1:0]        ddr_data,
    output logic                    ddr_data_valid,
    output logic                    ddr_data_last,
    input  logic                    ddr_data_ready
);
    localparam int PE_W   = bw(PE_NUM);
    localparam int PIDX_W = bw(PACK);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_ADDR, S_DATA, S_DONE} state_t;
    state_t state_reg, state_next;

    logic [DDR_ADDR_W-1:0] cur_addr_reg, pe_step_reg;
    logic [ADDR_W:0]       word_num_reg, rd_cnt_reg, pop_cnt_reg, pop_cnt_inc;
    logic [BURST_W-1:0]    beats_reg;
    logic [PE_NUM-1:0]     mask_reg;
    logic [PE_W-1:0]       cur_pe_reg, sel_idx;
    logic                  sel_found;
    logic                  inflight_reg;
    logic [DDR_W-1:0]      pack_reg, pack_merged, out_data_reg;
    logic [PIDX_W-1:0]     pack_idx_reg;
    logic                  out_valid_reg, out_last_reg;
    logic                  rd_issue, out_free, pop_final, pack_full, burst_end;
    logic                  fifo_pop;
    logic [RD_W-1:0]       fifo_dout;
    logic [CNT_W-1:0]      fifo_count, occupancy;

    // Lowest remaining mask bit (descending scan so the lowest wins).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (mask_reg[i]) begin
                sel_found = 1'b1;
                sel_idx   = i[PE_W-1:0];
            end
        end
    end

    // Reads are throttled so buffered plus in-flight words never exceed the FIFO.
    assign occupancy = fifo_count + CNT_W'(inflight_reg);
    assign rd_issue  = (state_reg == S_DATA) && (rd_cnt_reg < word_num_reg) &&
                       (occupancy < CNT_W'(FIFO_DEPTH));
    assign abuf_rd_addr = rd_issue ? rd_cnt_reg[ADDR_W-1:0] : '0;

    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_rd_en
        assign abuf_rd_en[gi] = rd_issue && (cur_pe_reg == PE_W'(gi));
    end

    // A word leaves the FIFO only when the beat register can take a new beat.
    assign out_free    = !out_valid_reg || ddr_data_ready;
    assign fifo_pop    = (state_reg == S_DATA) && (fifo_count != '0) && out_free;
    assign pop_cnt_inc = pop_cnt_reg + (ADDR_W+1)'(1);
    assign pop_final   = (pop_cnt_inc == word_num_reg);
    assign pack_full   = (pack_idx_reg == PIDX_W'(PACK - 1));
    assign burst_end   = (state_reg == S_DATA) && out_valid_reg && ddr_data_ready && out_last_reg;

    // Insert the popped word into its slot of the beat under construction.
    always_comb begin
        pack_merged = pack_reg;
        pack_merged[pack_idx_reg*RD_W +: RD_W] = fifo_dout;
    end

    pe2ddr_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (RD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_reg),
        .din   (abuf_rd_data[cur_pe_reg*RD_W +: RD_W]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and control outputs.
    always_comb begin
        state_next     = state_reg;
        busy           = (state_reg != S_IDLE);
        done           = 1'b0;
        ddr_addr_valid = 1'b0;
        ddr_addr       = '0;
        ddr_size       = '0;
        case (state_reg)
            S_IDLE: if (start) state_next = S_SEL;
            S_SEL:  state_next = sel_found ? S_ADDR : S_DONE;
            S_ADDR: begin
                ddr_addr_valid = 1'b1;
                ddr_addr       = cur_addr_reg;
                ddr_size       = beats_reg;
                if (ddr_addr_ready) state_next = S_DATA;
            end
            S_DATA: if (burst_end) state_next = S_SEL;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Configuration latch, per-PE counters, packing and the beat register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr_reg  <= '0;
            pe_step_reg   <= '0;
            word_num_reg  <= '0;
            beats_reg     <= '0;
            mask_reg      <= '0;
            cur_pe_reg    <= '0;
            rd_cnt_reg    <= '0;
            pop_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            pack_reg      <= '0;
            pack_idx_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            inflight_reg <= rd_issue;
            if (state_reg == S_IDLE && start) begin
                cur_addr_reg <= conf_st_addr;
                pe_step_reg  <= conf_pe_step;
                word_num_reg <= conf_word_num;
                beats_reg    <= BURST_W'((int'(conf_word_num) + PACK - 1) / PACK);
                mask_reg     <= conf_mask;
            end
            if (state_reg == S_SEL && sel_found) begin
                cur_pe_reg         <= sel_idx;
                mask_reg[sel_idx]  <= 1'b0;
                rd_cnt_reg         <= '0;
                pop_cnt_reg        <= '0;
                pack_reg           <= '0;
                pack_idx_reg       <= '0;
            end
            if (rd_issue) rd_cnt_reg <= rd_cnt_reg + (ADDR_W+1)'(1);
            if (out_valid_reg && ddr_data_ready) out_valid_reg <= 1'b0;
            if (fifo_pop) begin
                pop_cnt_reg <= pop_cnt_inc;
                if (pack_full || pop_final) begin
                    out_data_reg  <= pack_merged;
                    out_last_reg  <= pop_final;
                    out_valid_reg <= 1'b1;
                    pack_reg      <= '0;
                    pack_idx_reg  <= '0;
                end else begin
                    pack_reg     <= pack_merged;
                    pack_idx_reg <= pack_idx_reg + PIDX_W'(1);
                end
            end
            if (burst_end) cur_addr_reg <= cur_addr_reg + pe_step_reg;
        end
    end

    assign ddr_data       = out_data_reg;
    assign ddr_data_valid = out_valid_reg;
    assign ddr_data_last  = out_last_reg;

endmodule

// File: tb/tb_pe2ddr_wr.sv
// Self-checking bench for pe2ddr_wr: table of jobs with expected burst
// counts/addresses, a behavioural burst/beat model, and hand sequences for
// empty mask and mid-job reset.
module tb_pe2ddr_wr;
    import pe2ddr_wr_pkg::*;

    localparam int PE_NUM = 32;
    localparam int ADDR_W = 8;
    localparam int RD_W   = BATCH * DATA_W;
    localparam int PACK   = DDR_W / RD_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic                   done, busy;
    logic [DDR_ADDR_W-1:0]  conf_st_addr = '0, conf_pe_step = '0;
    logic [ADDR_W:0]        conf_word_num = '0;
    logic [PE_NUM-1:0]      conf_mask = '0;
    logic [ADDR_W-1:0]      abuf_rd_addr;
    logic [PE_NUM-1:0]      abuf_rd_en;
    logic [PE_NUM*RD_W-1:0] abuf_rd_data = '0;
    logic [DDR_ADDR_W-1:0]  ddr_addr;
    logic [BURST_W-1:0]     ddr_size;
    logic                   ddr_addr_valid, ddr_data_valid, ddr_data_last;
    logic                   ddr_addr_ready = 1'b0, ddr_data_ready = 1'b0;
    logic [DDR_W-1:0]       ddr_data;

    pe2ddr_wr dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .conf_st_addr(conf_st_addr), .conf_pe_step(conf_pe_step),
        .conf_word_num(conf_word_num), .conf_mask(conf_mask),
        .abuf_rd_addr(abuf_rd_addr), .abuf_rd_en(abuf_rd_en), .abuf_rd_data(abuf_rd_data),
        .ddr_addr(ddr_addr), .ddr_size(ddr_size), .ddr_addr_valid(ddr_addr_valid),
        .ddr_addr_ready(ddr_addr_ready), .ddr_data(ddr_data), .ddr_data_valid(ddr_data_valid),
        .ddr_data_last(ddr_data_last), .ddr_data_ready(ddr_data_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask; int wn; logic [31:0] st; logic [31:0] step;
        int rdy; int adly; bit restart;
        int e_bursts; int e_beats; logic [31:0] e_last_addr;
    } vec_t;
    typedef struct { logic [DDR_ADDR_W-1:0] addr; logic [BURST_W-1:0] size; } aw_t;
    typedef struct { logic [DDR_W-1:0] data; logic last; } w_t;

    aw_t got_aw[$], exp_aw[$];
    w_t  got_w[$],  exp_w[$];
    vec_t vec[8];

    int n_checks = 0, n_fail = 0;
    int rdy_pct = 100, addr_dly = 0, addr_wait = 0;
    int done_cnt = 0, rd_err = 0, proto_err = 0, lasts_seen = 0;
    logic [31:0] job_mask = '0, salt = '0;
    int job_wn = 0;
    logic prev_dv = 0, prev_dr = 0, prev_dl = 0, prev_av = 0, prev_ar = 0;
    logic [DDR_W-1:0] prev_dd = '0;
    logic [DDR_ADDR_W-1:0] prev_aa = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Buffer content: unique per (pe, address, job salt).
    function automatic logic [RD_W-1:0] word_of(input int pe, input int a, input logic [31:0] s);
        logic [15:0] mix;
        mix = s[15:0] ^ 16'(pe * 256 + a);
        return RD_W'({mix, 8'(pe), 8'(a)});
    endfunction

    // abuf model: one-cycle read latency; unselected lanes carry noise.
    always @(posedge clk) begin
        for (int i = 0; i < PE_NUM; i++)
            abuf_rd_data[i*RD_W +: RD_W] <= abuf_rd_en[i] ? word_of(i, int'(abuf_rd_addr), salt)
                                                         : RD_W'($urandom);
    end

    // Ready generation plus protocol monitor, all on the falling edge.
    always @(negedge clk) begin
        ddr_data_ready = ($urandom_range(99) < rdy_pct);
        if (ddr_addr_valid) begin
            ddr_addr_ready = (addr_wait >= addr_dly);
            addr_wait = ddr_addr_ready ? 0 : addr_wait + 1;
        end else begin
            ddr_addr_ready = (addr_dly == 0);
            addr_wait = 0;
        end
        if (rst) begin
            prev_dv = 0; prev_av = 0;
        end else begin
            if (prev_dv && !prev_dr &&
                (!ddr_data_valid || ddr_data !== prev_dd || ddr_data_last !== prev_dl))
                proto_err++;
            if (prev_av && !prev_ar && (!ddr_addr_valid || ddr_addr !== prev_aa))
                proto_err++;
            if (ddr_data_valid && got_aw.size() <= lasts_seen) proto_err++;
            if (abuf_rd_en != '0) begin
                if ($countones(abuf_rd_en) != 1 || (abuf_rd_en & ~job_mask) != '0 ||
                    int'(abuf_rd_addr) >= job_wn)
                    rd_err++;
            end
            if (done) done_cnt++;
            if (ddr_addr_valid && ddr_addr_ready) got_aw.push_back('{ddr_addr, ddr_size});
            if (ddr_data_valid && ddr_data_ready) begin
                got_w.push_back('{ddr_data, ddr_data_last});
                if (ddr_data_last) lasts_seen++;
            end
            prev_dv = ddr_data_valid; prev_dr = ddr_data_ready; prev_dd = ddr_data;
            prev_dl = ddr_data_last;  prev_av = ddr_addr_valid; prev_ar = ddr_addr_ready;
            prev_aa = ddr_addr;
        end
    end

    // Reference: bursts in ascending PE order at st + k*step, words packed LSB-first.
    task automatic build_model(input logic [31:0] mask, input int n,
                               input logic [31:0] st, input logic [31:0] step);
        int k, nb;
        w_t b;
        exp_aw.delete(); exp_w.delete();
        k  = 0;
        nb = (n + PACK - 1) / PACK;
        for (int pe = 0; pe < PE_NUM; pe++) begin
            if (mask[pe]) begin
                exp_aw.push_back('{st + 32'(k) * step, BURST_W'(nb)});
                k++;
                for (int bi = 0; bi < nb; bi++) begin
                    b.data = '0;
                    for (int j = 0; j < PACK; j++)
                        if (bi * PACK + j < n) b.data[j*RD_W +: RD_W] = word_of(pe, bi * PACK + j, salt);
                    b.last = (bi == nb - 1);
                    exp_w.push_back(b);
                end
            end
        end
    endtask

    task automatic clear_job(input logic [31:0] mask, input int wn);
        got_aw.delete(); got_w.delete();
        done_cnt = 0; rd_err = 0; proto_err = 0; lasts_seen = 0;
        job_mask = mask; job_wn = wn; salt = $urandom;
    endtask

    task automatic run_job(input vec_t v, input bit use_table, input string tag);
        int na, nw;
        clear_job(v.mask, v.wn);
        rdy_pct = v.rdy; addr_dly = v.adly;
        build_model(v.mask, v.wn, v.st, v.step);
        conf_mask = v.mask; conf_word_num = (ADDR_W+1)'(v.wn);
        conf_st_addr = v.st; conf_pe_step = v.step;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (v.restart) begin
            repeat (6) @(negedge clk);
            start = 1'b1; conf_mask = ~v.mask; conf_word_num = 9'd1; conf_st_addr = '1;
            @(negedge clk) start = 1'b0;
        end
        for (int c = 0; c < 30000 && done_cnt == 0; c++) @(negedge clk);
        check({tag, "_done_seen"}, done_cnt != 0, 1'b1);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_rd_err"}, rd_err, 0);
        check({tag, "_proto_err"}, proto_err, 0);
        if (use_table) begin
            check({tag, "_bursts"}, got_aw.size(), v.e_bursts);
            check({tag, "_beats"}, got_w.size(), v.e_beats);
            if (got_aw.size() > 0) check({tag, "_last_addr"}, got_aw[$].addr, v.e_last_addr);
        end
        check({tag, "_model_bursts"}, got_aw.size(), exp_aw.size());
        check({tag, "_model_beats"}, got_w.size(), exp_w.size());
        na = (got_aw.size() < exp_aw.size()) ? got_aw.size() : exp_aw.size();
        nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < na; i++) begin
            check($sformatf("%s_aw%0d_addr", tag, i), got_aw[i].addr, exp_aw[i].addr);
            check($sformatf("%s_aw%0d_size", tag, i), got_aw[i].size, exp_aw[i].size);
        end
        for (int i = 0; i < nw; i++) begin
            check($sformatf("%s_w%0d_data", tag, i), got_w[i].data, exp_w[i].data);
            check($sformatf("%s_w%0d_last", tag, i), got_w[i].last, exp_w[i].last);
        end
        if (done_cnt == 0) begin
            rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        end
    endtask

    initial begin
        vec_t rv;
        //         mask          wn   st            step        rdy adly rs bursts beats last_addr
        vec[0] = '{32'h0000_0005,   4, 32'h0000_1000, 32'h100, 100, 0, 1'b0,  2,   4, 32'h0000_1100};
        vec[1] = '{32'h0000_0001,   3, 32'h0000_2000, 32'h040, 100, 0, 1'b0,  1,   2, 32'h0000_2000};
        vec[2] = '{32'h0000_0003, 256, 32'h0000_0000, 32'h400,  50, 5, 1'b0,  2, 256, 32'h0000_0400};
        vec[3] = '{32'h8000_0000,   5, 32'hFFFF_FF00, 32'h100, 100, 0, 1'b0,  1,   3, 32'hFFFF_FF00};
        vec[4] = '{32'h8000_0001,   2, 32'hFFFF_FF00, 32'h100,  70, 2, 1'b0,  2,   2, 32'h0000_0000};
        vec[5] = '{32'hFFFF_FFFF,   1, 32'h0000_0010, 32'h008,  60, 1, 1'b0, 32,  32, 32'h0000_0108};
        vec[6] = '{32'h0000_A5A0,   7, 32'h0000_4000, 32'h020,  80, 1, 1'b1,  6,  24, 32'h0000_40A0};
        vec[7] = '{32'h0000_0001, 256, 32'h0000_0000, 32'h000, 100, 0, 1'b0,  1, 128, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, ddr_addr_valid, ddr_data_valid, ddr_data_last,
                                |abuf_rd_en, |ddr_data, |ddr_addr, |ddr_size}, 9'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(vec[i], 1'b1, $sformatf("vec%0d", i));

        // Empty mask: done two cycles after start, no traffic.
        clear_job(32'h0, 4);
        conf_mask = '0; conf_word_num = 9'd4;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("empty_done_c1", done, 1'b0);
        check("empty_busy_c1", busy, 1'b1);
        @(negedge clk);
        check("empty_done_c2", done, 1'b1);
        @(negedge clk);
        check("empty_done_c3", done, 1'b0);
        check("empty_busy_c3", busy, 1'b0);
        check("empty_traffic", got_aw.size() + got_w.size(), 0);
        check("empty_rd_err", rd_err, 0);

        // Reset during DATA: outputs clear immediately, no done.
        clear_job(32'h3, 16);
        rdy_pct = 50; addr_dly = 0;
        conf_mask = 32'h3; conf_word_num = 9'd16; conf_st_addr = 32'h100; conf_pe_step = 32'h10;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 200 && !ddr_data_valid; c++) @(negedge clk);
        check("rst_reached_data", ddr_data_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {busy, done, ddr_addr_valid, ddr_data_valid, ddr_data_last,
                                  |abuf_rd_en, |abuf_rd_addr, |ddr_data, |ddr_addr, |ddr_size}, 10'd0);
        repeat (3) @(negedge clk);
        check("rst_no_done", done_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        run_job(vec[0], 1'b1, "after_rst");

        // Randomised jobs checked against the model only.
        for (int r = 0; r < 4; r++) begin
            rv.mask = $urandom & $urandom & $urandom;
            rv.wn   = $urandom_range(1, 64);
            rv.st   = $urandom; rv.step = $urandom;
            rv.rdy  = $urandom_range(30, 100); rv.adly = $urandom_range(0, 4);
            rv.restart = 1'b0; rv.e_bursts = 0; rv.e_beats = 0; rv.e_last_addr = '0;
            run_job(rv, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
